// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit bridging the execute stage to a variable-latency
// data memory through a request/grant/response handshake. Builds byte-lane masks,
// lane-shifts store data, extends load data and reports misaligned, illegal and
// bus-timeout accesses as traps. One access in flight; o_done closes each access.
module lsu_mem_port #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic              o_mem_wen,
  output logic [XLEN/8-1:0] o_mem_mask,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_done,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_trap,
  output logic [1:0]        o_trap_cause
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] TO_LIMIT = TIMEOUT;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [OB-1:0]   off_q, off_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [NB-1:0]   mask_q, mask_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [OB-1:0]   off_in;
  logic            illegal_in, misaligned_in;
  logic [NB-1:0]   mask_in;
  logic [XLEN-1:0] shifted, load_ext;
  logic            timeout_hit;

  assign off_in = i_addr[OB-1:0];

  // Decode the incoming request: legality, alignment and byte lanes.
  always_comb begin
    illegal_in    = 1'b0;
    misaligned_in = 1'b0;
    mask_in       = '0;
    if (i_store) begin
      illegal_in = i_funct3[2] || ((i_funct3 == 3'b011) && (XLEN == 32));
    end else begin
      illegal_in = (i_funct3 == 3'b111) ||
                   (((i_funct3 == 3'b011) || (i_funct3 == 3'b110)) && (XLEN == 32));
    end
    case (i_funct3[1:0])
      2'b00: begin
        mask_in = NB'(1) << off_in;
      end
      2'b01: begin
        misaligned_in = i_addr[0];
        mask_in       = NB'(3) << off_in;
      end
      2'b10: begin
        misaligned_in = |i_addr[1:0];
        mask_in       = NB'(15) << off_in;
      end
      default: begin
        misaligned_in = |i_addr[2:0];
        mask_in       = '1;
      end
    endcase
  end

  // Move the addressed bytes down to bit 0 and extend them to XLEN.
  always_comb begin
    shifted = i_mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
      3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
      3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
      3'b100:  load_ext = XLEN'(shifted[7:0]);
      3'b101:  load_ext = XLEN'(shifted[15:0]);
      3'b110:  load_ext = XLEN'(shifted[31:0]);
      default: load_ext = shifted;
    endcase
  end

  // cnt_q counts REQ/WAIT cycles since accept; firing at cnt_q+2 places o_done
  // exactly TIMEOUT cycles after the accepting edge.
  assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd2) >= TO_LIMIT);

  // Next-state logic: accept/classify in IDLE, handshake in REQ/WAIT.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          store_d  = i_store;
          funct3_d = i_funct3;
          off_d    = off_in;
          addr_d   = {i_addr[XLEN-1:OB], {OB{1'b0}}};
          mask_d   = mask_in;
          wdata_d  = i_wdata << {off_in, 3'b000};
          rdata_d  = '0;
          cnt_d    = '0;
          if (illegal_in) begin
            cause_d = 2'b10;
            state_d = S_DONE;
          end else if (misaligned_in) begin
            cause_d = 2'b01;
            state_d = S_DONE;
          end else begin
            cause_d = 2'b00;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (i_mem_gnt) begin
          if (store_q) begin
            state_d = S_DONE;
          end else if (i_mem_rvalid) begin
            rdata_d = load_ext;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          cause_d = 2'b11;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (i_mem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          cause_d = 2'b11;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any in-flight access.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cause_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are gated by state so everything is 0 outside REQ/DONE.
  always_comb begin
    o_ready      = (state_q == S_IDLE);
    o_mem_req    = (state_q == S_REQ);
    o_mem_addr   = o_mem_req ? addr_q  : '0;
    o_mem_wen    = o_mem_req && store_q;
    o_mem_mask   = o_mem_req ? mask_q  : '0;
    o_mem_wdata  = o_mem_req ? wdata_q : '0;
    o_done       = (state_q == S_DONE);
    o_rdata      = o_done ? rdata_q : '0;
    o_trap       = o_done && (cause_q != 2'b00);
    o_trap_cause = o_done ? cause_q : 2'b00;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed bench for lsu_mem_port. Instance A is XLEN=32 with the
// default timeout, instance B is XLEN=64 with TIMEOUT=4. Both share request and
// memory-side stimulus; each has its own i_valid so only one is active at a time.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] addr = '0, wdata = '0, rdata = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;

  logic        a_ready, a_req, a_wen, a_done, a_trap;
  logic [31:0] a_maddr, a_mwdata, a_rdata;
  logic [3:0]  a_mask;
  logic [1:0]  a_cause;

  logic        b_ready, b_req, b_wen, b_done, b_trap;
  logic [63:0] b_maddr, b_mwdata, b_rdata;
  logic [7:0]  b_mask;
  logic [1:0]  b_cause;

  bit          sel = 1'b0;
  logic        obs_ready, obs_req, obs_wen, obs_done, obs_trap;
  logic [63:0] obs_maddr, obs_mwdata, obs_rdata;
  logic [7:0]  obs_mask;
  logic [1:0]  obs_cause;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(.XLEN(32), .TIMEOUT(64)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_a), .o_ready(a_ready),
    .i_store(store), .i_funct3(funct3), .i_addr(addr[31:0]), .i_wdata(wdata[31:0]),
    .o_mem_req(a_req), .i_mem_gnt(gnt), .o_mem_addr(a_maddr), .o_mem_wen(a_wen),
    .o_mem_mask(a_mask), .o_mem_wdata(a_mwdata), .i_mem_rvalid(rvalid),
    .i_mem_rdata(rdata[31:0]), .o_done(a_done), .o_rdata(a_rdata), .o_trap(a_trap),
    .o_trap_cause(a_cause)
  );

  lsu_mem_port #(.XLEN(64), .TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_b), .o_ready(b_ready),
    .i_store(store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_mem_req(b_req), .i_mem_gnt(gnt), .o_mem_addr(b_maddr), .o_mem_wen(b_wen),
    .o_mem_mask(b_mask), .o_mem_wdata(b_mwdata), .i_mem_rvalid(rvalid),
    .i_mem_rdata(rdata), .o_done(b_done), .o_rdata(b_rdata), .o_trap(b_trap),
    .o_trap_cause(b_cause)
  );

  // Observe whichever instance is under test.
  always_comb begin
    if (sel) begin
      obs_ready = b_ready;  obs_req = b_req;  obs_wen = b_wen;  obs_done = b_done;
      obs_trap = b_trap;    obs_maddr = b_maddr;  obs_mwdata = b_mwdata;
      obs_rdata = b_rdata;  obs_mask = b_mask;    obs_cause = b_cause;
    end else begin
      obs_ready = a_ready;  obs_req = a_req;  obs_wen = a_wen;  obs_done = a_done;
      obs_trap = a_trap;    obs_maddr = {32'b0, a_maddr};  obs_mwdata = {32'b0, a_mwdata};
      obs_rdata = {32'b0, a_rdata};  obs_mask = {4'b0, a_mask};  obs_cause = a_cause;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one access and follow it to o_done; gnt is given gd cycles into REQ,
  // rvalid rd cycles after the gnt cycle (loads only, when respond is set).
  task automatic run(input string name, input bit s, input bit st, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd_word,
                     input int gd, input int rd, input bit respond,
                     input int e_lat, input int e_reqc, input logic [63:0] e_maddr,
                     input logic [7:0] e_mask, input logic [63:0] e_mwdata,
                     input logic [63:0] e_r, input logic [1:0] e_cause);
    int lat, reqc, gnt_at;
    logic [63:0] c_maddr, c_mwdata, r;
    logic [7:0]  c_mask;
    logic        c_wen, trap;
    logic [1:0]  cause;
    lat = -1; reqc = 0; gnt_at = -1;
    c_maddr = '0; c_mwdata = '0; c_mask = '0; c_wen = 1'b0;
    r = '0; trap = 1'b0; cause = '0;
    sel = s;
    @(negedge clk);
    check({name, "_ready"}, 64'(obs_ready), 64'd1);
    store = st; funct3 = f3; addr = a; wdata = wd; rdata = rd_word;
    if (s) valid_b = 1'b1; else valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      gnt = 1'b0; rvalid = 1'b0;
      if (obs_req) begin
        if (reqc == 0) begin
          c_maddr = obs_maddr; c_mwdata = obs_mwdata; c_mask = obs_mask; c_wen = obs_wen;
        end else begin
          check({name, "_hold"}, {obs_maddr ^ c_maddr} | {obs_mwdata ^ c_mwdata} |
                64'({obs_mask ^ c_mask}) | 64'(obs_wen ^ c_wen), 64'd0);
        end
        reqc++;
        if (reqc == gd + 1) begin gnt = 1'b1; gnt_at = k; end
      end
      if (respond && !st && gnt_at >= 0 && k == gnt_at + rd) rvalid = 1'b1;
      if (obs_done) begin
        lat = k; r = obs_rdata; trap = obs_trap; cause = obs_cause;
      end
      if (lat < 0) @(negedge clk);
    end
    gnt = 1'b0; rvalid = 1'b0;
    check({name, "_lat"}, 64'(lat), 64'(e_lat));
    check({name, "_reqs"}, 64'(reqc), 64'(e_reqc));
    check({name, "_rdata"}, r, e_r);
    check({name, "_cause"}, 64'(cause), 64'(e_cause));
    check({name, "_trap"}, 64'(trap), 64'(e_cause != 2'b00));
    if (e_reqc != 0) begin
      check({name, "_maddr"}, c_maddr, e_maddr);
      check({name, "_mask"}, 64'(c_mask), 64'(e_mask));
      check({name, "_mwdata"}, c_mwdata, e_mwdata);
      check({name, "_wen"}, 64'(c_wen), 64'(st));
    end
    @(negedge clk);
    check({name, "_pulse"}, {63'b0, obs_done} | obs_rdata | 64'(obs_trap) | 64'(obs_cause), 64'd0);
    $display("txn %s: inst=%0d st=%0d f3=%0b addr=%h lat=%0d reqs=%0d rdata=%h cause=%0d",
             name, s, st, f3, a, lat, reqc, r, cause);
  endtask

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] e_maddr;
    logic [3:0]  e_mask;
    logic [31:0] e_mwdata, e_r;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // Immediate gnt with same-cycle rvalid on instance A.
    vecs[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h80AABBCC, 32'h1000, 4'h8, 32'h0,        32'hFFFFFF80, 2'd0};
    vecs[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0,        32'h80AABBCC, 32'h1000, 4'h8, 32'h0,        32'h00000080, 2'd0};
    vecs[2]  = '{1'b0, 3'b001, 32'h1002, 32'h0,        32'h80AABBCC, 32'h1000, 4'hC, 32'h0,        32'hFFFF80AA, 2'd0};
    vecs[3]  = '{1'b0, 3'b101, 32'h1000, 32'h0,        32'h80AABBCC, 32'h1000, 4'h3, 32'h0,        32'h0000BBCC, 2'd0};
    vecs[4]  = '{1'b0, 3'b010, 32'h1004, 32'h0,        32'h80AABBCC, 32'h1004, 4'hF, 32'h0,        32'h80AABBCC, 2'd0};
    vecs[5]  = '{1'b0, 3'b100, 32'h1001, 32'h0,        32'h12345678, 32'h1000, 4'h2, 32'h0,        32'h00000056, 2'd0};
    vecs[6]  = '{1'b1, 3'b000, 32'h5001, 32'h12345678, 32'h0,        32'h5000, 4'h2, 32'h34567800, 32'h0,        2'd0};
    vecs[7]  = '{1'b1, 3'b001, 32'h5002, 32'h0000BEEF, 32'h0,        32'h5000, 4'hC, 32'hBEEF0000, 32'h0,        2'd0};
    vecs[8]  = '{1'b1, 3'b010, 32'h5000, 32'hDEADBEEF, 32'h0,        32'h5000, 4'hF, 32'hDEADBEEF, 32'h0,        2'd0};
    vecs[9]  = '{1'b0, 3'b001, 32'h1001, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd1};
    vecs[10] = '{1'b0, 3'b011, 32'h1001, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd2};
    vecs[11] = '{1'b0, 3'b110, 32'h1000, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd2};
    vecs[12] = '{1'b0, 3'b111, 32'h1000, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd2};
    vecs[13] = '{1'b1, 3'b100, 32'h1000, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd2};
    vecs[14] = '{1'b1, 3'b011, 32'h1000, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd2};
    vecs[15] = '{1'b1, 3'b010, 32'h5002, 32'h0,        32'h0,        32'h0,    4'h0, 32'h0,        32'h0,        2'd1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready_a", 64'(a_ready), 64'd1);
    check("rst_ready_b", 64'(b_ready), 64'd1);
    check("rst_outs_a", {63'b0, a_req} | 64'(a_wen) | 64'(a_done) | 64'(a_trap) |
          64'(a_maddr) | 64'(a_mwdata) | 64'(a_rdata) | 64'(a_mask) | 64'(a_cause), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bit trapped;
      trapped = (vecs[i].e_cause != 2'd0);
      run($sformatf("vec%0d", i), 1'b0, vecs[i].st, vecs[i].f3, {32'b0, vecs[i].addr},
          {32'b0, vecs[i].wdata}, {32'b0, vecs[i].rdata}, 0, 0, 1'b1,
          trapped ? 1 : 2, trapped ? 0 : 1, {32'b0, vecs[i].e_maddr},
          {4'b0, vecs[i].e_mask}, {32'b0, vecs[i].e_mwdata}, {32'b0, vecs[i].e_r},
          vecs[i].e_cause);
    end

    // lb with rvalid two cycles after gnt.
    run("lb_slow", 1'b0, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80AABBCC, 0, 2, 1'b1,
        4, 1, 64'h1000, 8'h08, 64'h0, 64'hFFFFFF80, 2'd0);
    // sh with gnt delayed by three cycles: request held for four cycles.
    run("sh_slow", 1'b0, 1'b1, 3'b001, 64'h2002, 64'h0000BEEF, 64'h0, 3, 0, 1'b1,
        5, 4, 64'h2000, 8'h0C, 64'hBEEF0000, 64'h0, 2'd0);
    // Misaligned lw traps on the cycle after accept.
    run("lw_mis", 1'b0, 1'b0, 3'b010, 64'h3001, 64'h0, 64'h0, 0, 0, 1'b1,
        1, 0, 64'h0, 8'h0, 64'h0, 64'h0, 2'd1);

    // Reset asserted mid-WAIT abandons the access.
    sel = 1'b0;
    @(negedge clk);
    store = 1'b0; funct3 = 3'b010; addr = 64'h1000; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("rw_req", 64'(obs_req), 64'd1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("rw_wait", {63'b0, obs_req} | 64'(obs_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rw_async_ready", 64'(obs_ready), 64'd1);
    check("rw_no_done", 64'(obs_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; rdata = 64'h55; rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rw_ignored", {63'b0, obs_done} | 64'(obs_req) | 64'({~obs_ready}), 64'd0);
      @(negedge clk);
    end
    $display("txn reset_mid_wait: ready=%0d done=%0d", obs_ready, obs_done);

    // Instance B: XLEN=64, TIMEOUT=4.
    run("ld", 1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 64'h1122334455667788, 0, 0, 1'b1,
        2, 1, 64'h4008, 8'hFF, 64'h0, 64'h1122334455667788, 2'd0);
    run("lwu", 1'b1, 1'b0, 3'b110, 64'h4004, 64'h0, 64'h8000000100000000, 0, 0, 1'b1,
        2, 1, 64'h4000, 8'hF0, 64'h0, 64'h0000000080000001, 2'd0);
    run("lw64", 1'b1, 1'b0, 3'b010, 64'h4004, 64'h0, 64'h8000000100000000, 0, 0, 1'b1,
        2, 1, 64'h4000, 8'hF0, 64'h0, 64'hFFFFFFFF80000001, 2'd0);
    run("sd", 1'b1, 1'b1, 3'b011, 64'h4008, 64'hA5A5000012345678, 64'h0, 0, 0, 1'b1,
        2, 1, 64'h4008, 8'hFF, 64'hA5A5000012345678, 64'h0, 2'd0);
    run("ld_mis", 1'b1, 1'b0, 3'b011, 64'h4004, 64'h0, 64'h0, 0, 0, 1'b1,
        1, 0, 64'h0, 8'h0, 64'h0, 64'h0, 2'd1);
    run("timeout", 1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 64'hFFFF, 0, 0, 1'b0,
        4, 1, 64'h4000, 8'hFF, 64'h0, 64'h0, 2'd3);
    run("to_race", 1'b1, 1'b0, 3'b000, 64'h4001, 64'h0, 64'h7F00, 0, 2, 1'b1,
        4, 1, 64'h4000, 8'h02, 64'h0, 64'h7F, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
